// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks in-flight register writes across the EXE / MEM (and optional WB)
//   pipeline slots so a hazard detector can see which registers are still
//   owed a write-back. It also counts the cycles in which an issue was
//   refused because of a hazard.
//
//   Configuration macro: SB_WB_STAGE_EN
//     - defined:   a WB slot follows MEM and contributes to pending.
//     - undefined: MEM contents are dropped on advance, and pending covers
//                  EXE and MEM only.
//
//   Ports
//     clk, rst            single clock, synchronous active-high reset
//     issue_valid         decode stage presents an instruction
//     issue_wb_en         issued instruction writes the register file
//     issue_mem_r         issued instruction is a load
//     issue_rd[3:0]       destination register of the issued instruction
//     hazard              hazard detector requests a bubble
//     flush               taken branch; the decode instruction is discarded
//     mem_stall           the whole back end freezes
//     WB_EXE, EXE_MEM_R   EXE slot write-back / load flags
//     WB_MEM              MEM slot write-back flag
//     RD_EXE, RD_MEM      EXE / MEM destination registers (0 when the slot is empty)
//     pending[15:0]       bit r set while any valid writing slot targets r
//     issue_ready         the decode instruction is accepted this cycle
//     bubble_cnt          saturating count of hazard-refused issue cycles
module reg_scoreboard #(
  parameter int NSTALL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic                issue_mem_r,
  input  logic [3:0]          issue_rd,
  input  logic                hazard,
  input  logic                flush,
  input  logic                mem_stall,
  output logic                WB_EXE,
  output logic                EXE_MEM_R,
  output logic                WB_MEM,
  output logic [3:0]          RD_EXE,
  output logic [3:0]          RD_MEM,
  output logic [15:0]         pending,
  output logic                issue_ready,
  output logic [NSTALL_W-1:0] bubble_cnt
);

  // One-hot decode of a register index.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  logic                exe_valid_q, exe_valid_d;
  logic                exe_wb_q,    exe_wb_d;
  logic                exe_memr_q,  exe_memr_d;
  logic [3:0]          exe_rd_q,    exe_rd_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_wb_q,    mem_wb_d;
  logic                mem_memr_q,  mem_memr_d;
  logic [3:0]          mem_rd_q,    mem_rd_d;
`ifdef SB_WB_STAGE_EN
  logic                wb_valid_q,  wb_valid_d;
  logic                wb_wb_q,     wb_wb_d;
  logic [3:0]          wb_rd_q,     wb_rd_d;
`endif
  logic [NSTALL_W-1:0] cnt_q,       cnt_d;

  assign issue_ready = ~mem_stall & ~hazard & ~flush;

  // Next-state: hold everything on stall, otherwise shift slots and load EXE.
  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_wb_d    = exe_wb_q;
    exe_memr_d  = exe_memr_q;
    exe_rd_d    = exe_rd_q;
    mem_valid_d = mem_valid_q;
    mem_wb_d    = mem_wb_q;
    mem_memr_d  = mem_memr_q;
    mem_rd_d    = mem_rd_q;
`ifdef SB_WB_STAGE_EN
    wb_valid_d  = wb_valid_q;
    wb_wb_d     = wb_wb_q;
    wb_rd_d     = wb_rd_q;
`endif
    cnt_d       = cnt_q;
    if (!mem_stall) begin
`ifdef SB_WB_STAGE_EN
      wb_valid_d  = mem_valid_q;
      wb_wb_d     = mem_wb_q;
      wb_rd_d     = mem_rd_q;
`endif
      mem_valid_d = exe_valid_q;
      mem_wb_d    = exe_wb_q;
      mem_memr_d  = exe_memr_q;
      mem_rd_d    = exe_rd_q;
      if (issue_valid && issue_ready) begin
        exe_valid_d = 1'b1;
        exe_wb_d    = issue_wb_en;
        exe_memr_d  = issue_mem_r;
        exe_rd_d    = issue_rd;
      end else begin
        exe_valid_d = 1'b0;
        exe_wb_d    = 1'b0;
        exe_memr_d  = 1'b0;
        exe_rd_d    = 4'd0;
      end
      // A flush takes priority over a hazard, so a flushed issue is not
      // counted as a bubble.
      if (issue_valid && hazard && !flush && (cnt_q != {NSTALL_W{1'b1}})) begin
        cnt_d = cnt_q + {{(NSTALL_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_q <= 1'b0;
      exe_wb_q    <= 1'b0;
      exe_memr_q  <= 1'b0;
      exe_rd_q    <= 4'd0;
      mem_valid_q <= 1'b0;
      mem_wb_q    <= 1'b0;
      mem_memr_q  <= 1'b0;
      mem_rd_q    <= 4'd0;
`ifdef SB_WB_STAGE_EN
      wb_valid_q  <= 1'b0;
      wb_wb_q     <= 1'b0;
      wb_rd_q     <= 4'd0;
`endif
      cnt_q       <= {NSTALL_W{1'b0}};
    end else begin
      exe_valid_q <= exe_valid_d;
      exe_wb_q    <= exe_wb_d;
      exe_memr_q  <= exe_memr_d;
      exe_rd_q    <= exe_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_wb_q    <= mem_wb_d;
      mem_memr_q  <= mem_memr_d;
      mem_rd_q    <= mem_rd_d;
`ifdef SB_WB_STAGE_EN
      wb_valid_q  <= wb_valid_d;
      wb_wb_q     <= wb_wb_d;
      wb_rd_q     <= wb_rd_d;
`endif
      cnt_q       <= cnt_d;
    end
  end

  // Pending map from slot state only; the issue in flight this cycle is not bypassed.
  always_comb begin
    pending = 16'h0000;
    if (exe_valid_q && exe_wb_q) begin
      pending = pending | onehot16(exe_rd_q);
    end else begin
      pending = pending;
    end
    if (mem_valid_q && mem_wb_q) begin
      pending = pending | onehot16(mem_rd_q);
    end else begin
      pending = pending;
    end
`ifdef SB_WB_STAGE_EN
    if (wb_valid_q && wb_wb_q) begin
      pending = pending | onehot16(wb_rd_q);
    end else begin
      pending = pending;
    end
`endif
  end

  assign WB_EXE     = exe_valid_q & exe_wb_q;
  assign EXE_MEM_R  = exe_valid_q & exe_memr_q;
  assign WB_MEM     = mem_valid_q & mem_wb_q;
  assign RD_EXE     = exe_valid_q ? exe_rd_q : 4'd0;
  assign RD_MEM     = mem_valid_q ? mem_rd_q : 4'd0;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_wb_en, issue_mem_r, hazard, flush, mem_stall;
  logic [3:0]  issue_rd;
  logic        WB_EXE, EXE_MEM_R, WB_MEM, issue_ready;
  logic [3:0]  RD_EXE, RD_MEM;
  logic [15:0] pending;
  logic [7:0]  bubble_cnt;
  int errors = 0;
  int checks = 0;

  reg_scoreboard #(.NSTALL_W(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_mem_r(issue_mem_r), .issue_rd(issue_rd), .hazard(hazard), .flush(flush),
    .mem_stall(mem_stall), .WB_EXE(WB_EXE), .EXE_MEM_R(EXE_MEM_R), .WB_MEM(WB_MEM),
    .RD_EXE(RD_EXE), .RD_MEM(RD_MEM), .pending(pending), .issue_ready(issue_ready),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic wb, input logic mr, input logic [3:0] rd);
    issue_valid = v; issue_wb_en = wb; issue_mem_r = mr; issue_rd = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wbexe"}, WB_EXE, 0);
    chk({tag, "_memr"}, EXE_MEM_R, 0);
    chk({tag, "_wbmem"}, WB_MEM, 0);
    chk({tag, "_rdexe"}, RD_EXE, 0);
    chk({tag, "_rdmem"}, RD_MEM, 0);
    chk({tag, "_pend"}, pending, 0);
    chk({tag, "_bcnt"}, bubble_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_ready", issue_ready, 1);

    // Basic latency: rd=5 write
    issue(1'b1, 1'b1, 1'b0, 4'd5);
    #1 chk("lat_ready", issue_ready, 1);
    step();
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    chk("lat1_wbexe", WB_EXE, 1);
    chk("lat1_rdexe", RD_EXE, 5);
    chk("lat1_pend", pending, 16'h0020);
    step();
    chk("lat2_wbmem", WB_MEM, 1);
    chk("lat2_rdmem", RD_MEM, 5);
    chk("lat2_wbexe", WB_EXE, 0);
    chk("lat2_pend", pending, 16'h0020);
    step();
`ifdef SB_WB_STAGE_EN
    chk("lat3_pend", pending, 16'h0020);
    step();
`endif
    chk("lat_clear_pend", pending, 16'h0000);
    chk("lat_clear_wbmem", WB_MEM, 0);

    // Load then hazard
    issue(1'b1, 1'b1, 1'b1, 4'd3);
    step();
    chk("ld_memr", EXE_MEM_R, 1);
    chk("ld_rdexe", RD_EXE, 3);
    issue(1'b1, 1'b1, 1'b0, 4'd6);
    hazard = 1'b1;
    #1 chk("hz_ready", issue_ready, 0);
    step();
    chk("hz_wbexe", WB_EXE, 0);
    chk("hz_rdexe", RD_EXE, 0);
    chk("hz_bcnt", bubble_cnt, 1);
    chk("hz_rdmem", RD_MEM, 3);
    chk("hz_pend", pending, 16'h0008);

    // Saturation: 1 + 253 = 254, then saturate at 255
    for (int i = 0; i < 253; i++) step();
    chk("sat_254", bubble_cnt, 254);
    for (int i = 0; i < 47; i++) step();
    chk("sat_255", bubble_cnt, 255);
    chk("sat_pend", pending, 16'h0000);

    // Hazard with no issue does not count (saturated counter reset first)
    hazard = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_bcnt", bubble_cnt, 0);
    hazard = 1'b1;
    step();
    chk("hz_noissue_bcnt", bubble_cnt, 0);
    hazard = 1'b0;

    // Stall holds the slots
    issue(1'b1, 1'b1, 1'b0, 4'd2);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd7);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd11);
    hazard = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_rdexe", RD_EXE, 7);
      chk("stall_rdmem", RD_MEM, 2);
      chk("stall_pend", pending, 16'h0084);
      chk("stall_bcnt", bubble_cnt, 0);
      chk("stall_ready", issue_ready, 0);
    end
    mem_stall = 1'b0;
    hazard = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("rel_wbexe", WB_EXE, 0);
    chk("rel_rdmem", RD_MEM, 7);
    chk("rel_pend", pending, 16'h0080);
    step(); step();
    chk("drain_pend", pending, 16'h0000);

    // Flush with hazard: flush wins, no count
    issue(1'b1, 1'b1, 1'b0, 4'd9);
    flush = 1'b1;
    hazard = 1'b1;
    #1 chk("fl_ready", issue_ready, 0);
    step();
    chk("fl_rdexe", RD_EXE, 0);
    chk("fl_pend", pending, 16'h0000);
    chk("fl_bcnt", bubble_cnt, 0);
    flush = 1'b0;
    hazard = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("fl_pend2", pending, 16'h0000);

    // Non-writing instruction occupies a slot but is invisible to pending
    issue(1'b1, 1'b0, 1'b0, 4'd12);
    step();
    chk("nowb_wbexe", WB_EXE, 0);
    chk("nowb_rdexe", RD_EXE, 12);
    chk("nowb_pend", pending, 16'h0000);

    // Same rd twice, then reset during stall
    issue(1'b1, 1'b1, 1'b0, 4'd4);
    step();
    step();
    chk("dup_pend", pending, 16'h0010);
    chk("dup_wbexe", WB_EXE, 1);
    chk("dup_wbmem", WB_MEM, 1);
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("dup_last_pend", pending, 16'h0010);
    issue(1'b1, 1'b1, 1'b0, 4'd4);
    step();
    issue(1'b1, 1'b1, 1'b0, 4'd4);
    step();
    rst = 1'b1;
    mem_stall = 1'b1;
    step();
    chk_all_zero("rst3");
    rst = 1'b0;
    mem_stall = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("post_rst_pend", pending, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
